if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, meaning the reset; asynchronous, active-high.
REQ-004 SHALL have port pc, output, 32, meaning the current fetch PC, fed to the PC mux.
REQ-005 SHALL have port next_pc, input, 32, meaning the mux result (pc+4, branch target or jump target).
REQ-006 SHALL have port redirect, input, 1, meaning branch or jump taken this cycle.
REQ-007 SHALL have ports imem_req_valid (output, 1), imem_req_ready (input, 1) and imem_req_addr (output, 32), meaning the instruction-memory request handshake.
REQ-008 SHALL have ports imem_resp_valid (input, 1) and imem_resp_data (input, 32), meaning the instruction-memory response; it has no back-pressure.
REQ-009 SHALL have ports if_valid (output, 1), if_ready (input, 1), if_pc (output, 32), if_instr (output, 32) and if_misalign (output, 1), meaning the instruction handed to decode.

Function
REQ-010 SHALL implement FSM states S_REQ, S_WAIT and S_HOLD, with at most one outstanding memory request.
REQ-011 SHALL drive imem_req_valid=1 only in S_REQ with pc[1:0]==2'b00, and imem_req_addr=pc.
REQ-012 In S_REQ, on request handshake, SHALL capture pc into if_pc, load pc<=next_pc and move to S_WAIT.
REQ-013 In S_REQ with pc[1:0]!=0, SHALL issue no request, load if_pc<=pc, if_instr<=32'h0000_0013 and if_misalign<=1, and move to S_HOLD.
REQ-014 In S_WAIT, on imem_resp_valid with the kill flag clear, SHALL load if_instr<=imem_resp_data and if_misalign<=0, and move to S_HOLD.
REQ-015 In S_WAIT, on imem_resp_valid with the kill flag set, SHALL discard the data, clear kill and move to S_REQ.
REQ-016 SHALL assert if_valid exactly while in S_HOLD; if_pc, if_instr and if_misalign SHALL be stable while if_valid=1 and if_ready=0.
REQ-017 In S_HOLD, on if_ready=1, SHALL move to S_REQ; minimum latency SHALL be request-accept to if_valid = 2 cycles when the response arrives the cycle after the request.
REQ-018 redirect SHALL load pc<=next_pc in every state; without redirect, pc SHALL change only on a request handshake.
REQ-019 redirect in S_REQ coincident with a handshake SHALL set kill and go to S_WAIT.
REQ-020 redirect in S_WAIT without imem_resp_valid SHALL set kill.
REQ-021 redirect in S_WAIT with imem_resp_valid SHALL discard the data and go to S_REQ.
REQ-022 redirect in S_HOLD SHALL drop the held instruction and go to S_REQ, overriding a coincident if_ready.
REQ-023 All PC arithmetic SHALL be external; pc SHALL be an unsigned 32-bit value with no wrap checks.

Reset
REQ-024 On rst, asynchronously, SHALL set state=S_REQ, pc=RESET_PC, kill=0, if_valid=0, if_pc=0, if_instr=32'h0000_0013 and if_misalign=0.
REQ-025 Reset mid-transaction SHALL abandon the outstanding request; the memory SHALL be reset on the same rst.
REQ-026 The first request after rst deassertion SHALL be issued in the first clock cycle after deassertion, to address RESET_PC.

Structure
REQ-027 The state encoding, NOP constant 32'h0000_0013 and default RESET_PC SHALL live in a shared package.
REQ-028 The output holding register (if_pc/if_instr/if_misalign plus valid) SHALL be one sub-module, if_out_buf; the FSM and pc register SHALL stay in if_stage.

Verification
REQ-029 Reset release, memory always ready with 1-cycle response, if_ready=1 -> requests to 0x0, 0x4 and 0x8 in order; if_instr matches the memory contents.
REQ-030 Hold if_ready=0 for 5 cycles in S_HOLD -> if_valid stays 1, if_pc/if_instr unchanged, and no new imem request.
REQ-031 redirect with next_pc=0x100 while in S_WAIT for 0x8 -> the 0x8 response is dropped, the next request goes to 0x100, and the next if_pc=0x100.
REQ-032 redirect coincident with imem_resp_valid in S_WAIT, and separately with if_ready=1 in S_HOLD -> nothing is delivered, and the next request goes to the redirect target.
REQ-033 redirect to 0x102 -> no imem request; if_valid with if_pc=0x102, if_instr=0x00000013 and if_misalign=1.
REQ-034 Assert rst while in S_WAIT with imem_req_ready toggling randomly -> after release, pc=RESET_PC, if_valid=0, and the first request goes to RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and
// architectural constants.
package if_stage_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } if_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_out_buf.sv
// Holding register for the instruction presented to decode. Contents stay
// frozen between loads, so they are stable for as long as decode stalls.
module if_out_buf
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_pc,
   input  logic [31:0] pc_in,
   input  logic        load_instr,
   input  logic [31:0] instr_in,
   input  logic        misalign_in,
   input  logic        drop,
   output logic        valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_misalign
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid        <= 1'b0;
         out_pc       <= '0;
         out_instr    <= NOP_INSTR;
         out_misalign <= 1'b0;
      end else begin
         if (load_pc) begin
            out_pc <= pc_in;
         end
         // Loading an instruction is what makes the entry visible to decode.
         if (load_instr) begin
            out_instr    <= instr_in;
            out_misalign <= misalign_in;
            valid        <= 1'b1;
         end else if (drop) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues at most one instruction-memory
// request at a time and hands each fetched instruction to decode.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc,
   input  logic [31:0] next_pc,
   input  logic        redirect,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_misalign,
   output if_state_e   dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and the payload is held until it
   // transfers. The memory response is a one-cycle pulse with no back-pressure.

   if_state_e   state, state_nxt;
   logic        kill, kill_nxt;
   logic        aligned;
   logic        req_fire;
   logic        load_pc;
   logic        load_instr;
   logic [31:0] instr_sel;
   logic        misalign_sel;
   logic        drop;

   assign aligned        = (pc[1:0] == 2'b00);
   assign imem_req_valid = (state == S_REQ) && aligned;
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign dbg_state      = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_REQ;
         pc    <= RESET_PC;
         kill  <= 1'b0;
      end else begin
         state <= state_nxt;
         kill  <= kill_nxt;
         if (redirect || req_fire) begin
            pc <= next_pc;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      kill_nxt     = kill;
      load_pc      = 1'b0;
      load_instr   = 1'b0;
      instr_sel    = NOP_INSTR;
      misalign_sel = 1'b0;
      drop         = 1'b0;
      case (state)
         S_REQ: begin
            if (!aligned) begin
               // A redirect replaces the faulting PC before it is reported.
               if (!redirect) begin
                  load_pc      = 1'b1;
                  load_instr   = 1'b1;
                  misalign_sel = 1'b1;
                  state_nxt    = S_HOLD;
               end
            end else if (imem_req_ready) begin
               load_pc   = 1'b1;
               state_nxt = S_WAIT;
               if (redirect) begin
                  kill_nxt = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               if (kill || redirect) begin
                  kill_nxt  = 1'b0;
                  state_nxt = S_REQ;
               end else begin
                  load_instr = 1'b1;
                  instr_sel  = imem_resp_data;
                  state_nxt  = S_HOLD;
               end
            end else if (redirect) begin
               kill_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect || if_ready) begin
               drop      = 1'b1;
               state_nxt = S_REQ;
            end
         end
         default: begin
            state_nxt = S_REQ;
         end
      endcase
   end

   if_out_buf u_out_buf (
      .clk          (clk),
      .rst          (rst),
      .load_pc      (load_pc),
      .pc_in        (pc),
      .load_instr   (load_instr),
      .instr_in     (instr_sel),
      .misalign_in  (misalign_sel),
      .drop         (drop),
      .valid        (if_valid),
      .out_pc       (if_pc),
      .out_instr    (if_instr),
      .out_misalign (if_misalign)
   );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory model with variable latency, randomized stalls
// and redirects, and a scoreboard fed by a program-flow reference model.
module tb_if_stage;
   import if_stage_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        redirect;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_misalign;
   if_state_e   dbg_state;
   logic [31:0] redir_target;

   int total     = 0;
   int bad       = 0;
   int deliv_cnt = 0;
   int mem_lat   = 1;
   int ready_pct = 100;
   int out_pct   = 100;

   // expected request addresses, and expected {pc, instr, misalign} deliveries
   logic [31:0] req_exp_q[$];
   logic [64:0] out_exp_q[$];

   // external PC mux
   assign next_pc = redirect ? redir_target : pc + 32'd4;

   if_stage #(.RESET_PC(RPC)) dut (
      .clk             (clk),
      .rst             (rst),
      .pc              (pc),
      .next_pc         (next_pc),
      .redirect        (redirect),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_pc           (if_pc),
      .if_instr        (if_instr),
      .if_misalign     (if_misalign),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // ---------------- instruction memory model ----------------
   logic        hs_seen;
   logic [31:0] hs_addr;
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_cnt;

   initial begin
      hs_seen = 1'b0;
      hs_addr = '0;
      forever begin
         @(negedge clk);
         hs_seen = imem_req_valid && imem_req_ready && !rst;
         hs_addr = imem_req_addr;
      end
   end

   initial begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      pend            = 1'b0;
      pend_addr       = '0;
      pend_cnt        = 0;
      forever begin
         @(posedge clk);
         #1;
         imem_resp_valid = 1'b0;
         if (rst) begin
            pend = 1'b0;
         end else begin
            if (hs_seen) begin
               pend      = 1'b1;
               pend_addr = hs_addr;
               pend_cnt  = mem_lat;
            end
            if (pend) begin
               pend_cnt--;
               if (pend_cnt == 0) begin
                  imem_resp_valid = 1'b1;
                  imem_resp_data  = mem_word(pend_addr);
                  pend            = 1'b0;
               end
            end
         end
         imem_req_ready = ($urandom_range(99) < ready_pct);
      end
   end

   // ---------------- decode-side ready driver ----------------
   initial begin
      if_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if_ready = ($urandom_range(99) < out_pct);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   // Model: fetches proceed sequentially from the last target; a redirect
   // discards everything fetched but not yet delivered. A misaligned PC is
   // never requested and reports itself as a NOP with the misalign flag,
   // repeatedly, until redirected away.
   logic        prev_hold;
   logic [64:0] prev_out;
   logic [31:0] ea;
   logic [64:0] eo;

   initial begin
      prev_hold = 1'b0;
      prev_out  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            req_exp_q.delete();
            out_exp_q.delete();
            req_exp_q.push_back(RPC);
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               check1("hold_valid", if_valid, 1'b1);
               check32("hold_pc", if_pc, prev_out[64:33]);
               check32("hold_instr", if_instr, prev_out[32:1]);
               check1("hold_misalign", if_misalign, prev_out[0]);
            end
            if (if_valid) begin
               check1("no_req_in_hold", imem_req_valid, 1'b0);
            end
            if (imem_req_valid && imem_req_ready) begin
               if (req_exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_req: got addr %h required no request", imem_req_addr);
               end else begin
                  ea = req_exp_q.pop_front();
                  check32("req_addr", imem_req_addr, ea);
                  if (!redirect) begin
                     out_exp_q.push_back({ea, mem_word(ea), 1'b0});
                     req_exp_q.push_back(ea + 32'd4);
                  end
               end
            end
            if (if_valid && if_ready && !redirect) begin
               deliv_cnt++;
               if (out_exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_out: got pc %h required no delivery", if_pc);
               end else begin
                  eo = out_exp_q.pop_front();
                  check32("out_pc", if_pc, eo[64:33]);
                  check32("out_instr", if_instr, eo[32:1]);
                  check1("out_misalign", if_misalign, eo[0]);
                  if (eo[0]) begin
                     out_exp_q.push_back(eo);
                  end
               end
            end
            if (redirect) begin
               req_exp_q.delete();
               out_exp_q.delete();
               if (redir_target[1:0] == 2'b00) begin
                  req_exp_q.push_back(redir_target);
               end else begin
                  out_exp_q.push_back({redir_target, NOP_INSTR, 1'b1});
               end
            end
            prev_hold = if_valid && !if_ready && !redirect;
            prev_out  = {if_pc, if_instr, if_misalign};
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_redirect(input logic [31:0] t);
      redir_target = t;
      redirect     = 1'b1;
      tick();
      redirect     = 1'b0;
   endtask

   task automatic wait_deliv(input string name, input int n, input int budget);
      int start;
      int k;
      start = deliv_cnt;
      k     = 0;
      while (deliv_cnt < start + n && k < budget) begin
         tick();
         k++;
      end
      total++;
      if (deliv_cnt < start + n) begin
         bad++;
         $display("FAIL %s: got %0d deliveries required %0d", name, deliv_cnt - start, n);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      redirect = 1'b0;
      repeat (3) tick();
      check32("rst_pc", pc, RPC);
      check1("rst_valid", if_valid, 1'b0);
      check32("rst_if_pc", if_pc, 32'h0);
      check32("rst_if_instr", if_instr, NOP_INSTR);
      check1("rst_misalign", if_misalign, 1'b0);
      rst = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int k;
      int d0;
      logic [31:0] held_pc;
      logic [31:0] held_instr;

      rst          = 1'b1;
      redirect     = 1'b0;
      redir_target = '0;

      // reset release, back-to-back fetch with 1-cycle memory
      mem_lat   = 1;
      ready_pct = 100;
      out_pct   = 100;
      do_reset();
      @(negedge clk);
      check1("first_req_valid", imem_req_valid, 1'b1);
      check32("first_req_addr", imem_req_addr, RPC);
      @(negedge clk);
      check1("lat_c1_valid", if_valid, 1'b0);
      @(negedge clk);
      check1("lat_c2_valid", if_valid, 1'b1);
      check32("lat_c2_pc", if_pc, RPC);
      wait_deliv("seq_fetch", 3, 40);

      // decode stall for 5 cycles
      out_pct = 0;
      k = 0;
      while (!(if_valid && !if_ready) && k < 50) begin
         tick();
         k++;
      end
      check1("stall_reached", if_valid && !if_ready, 1'b1);
      held_pc    = if_pc;
      held_instr = if_instr;
      repeat (5) begin
         tick();
         check1("stall_valid", if_valid, 1'b1);
         check1("stall_no_req", imem_req_valid, 1'b0);
         check32("stall_pc", if_pc, held_pc);
         check32("stall_instr", if_instr, held_instr);
      end
      out_pct = 100;
      wait_deliv("stall_release", 1, 40);

      // redirect while waiting for the 0x8 response
      mem_lat = 3;
      do_reset();
      k = 0;
      while (!(pend && pend_addr == 32'h8 && !imem_resp_valid) && k < 100) begin
         tick();
         k++;
      end
      check1("wait_for_0x8", pend && pend_addr == 32'h8, 1'b1);
      pulse_redirect(32'h0000_0100);
      wait_deliv("after_redir_wait", 2, 60);

      // redirect coincident with the memory response
      mem_lat = 2;
      k = 0;
      while (!imem_resp_valid && k < 100) begin
         tick();
         k++;
      end
      check1("resp_seen", imem_resp_valid, 1'b1);
      pulse_redirect(32'h0000_0200);
      wait_deliv("after_redir_resp", 2, 60);

      // redirect coincident with if_ready in the hold state
      k = 0;
      while (!(if_valid && if_ready) && k < 100) begin
         tick();
         k++;
      end
      check1("hold_seen", if_valid && if_ready, 1'b1);
      pulse_redirect(32'h0000_0300);
      wait_deliv("after_redir_hold", 2, 60);

      // misaligned target
      pulse_redirect(32'h0000_0102);
      wait_deliv("misalign_deliv", 2, 60);
      pulse_redirect(32'h0000_0400);
      wait_deliv("after_misalign", 2, 60);

      // reset while a request is outstanding, memory ready toggling
      ready_pct = 50;
      mem_lat   = 3;
      k = 0;
      while (!pend && k < 100) begin
         tick();
         k++;
      end
      check1("pend_before_rst", pend, 1'b1);
      rst = 1'b1;
      repeat (2) tick();
      check32("midrst_pc", pc, RPC);
      check1("midrst_valid", if_valid, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check1("post_rst_req_valid", imem_req_valid, 1'b1);
      check32("post_rst_req_addr", imem_req_addr, RPC);
      check1("post_rst_if_valid", if_valid, 1'b0);
      wait_deliv("post_rst_deliv", 2, 100);

      // randomized traffic with occasional aligned redirects
      d0 = deliv_cnt;
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) begin
            mem_lat   = $urandom_range(4, 1);
            ready_pct = $urandom_range(100, 30);
            out_pct   = $urandom_range(100, 30);
         end
         if ($urandom_range(99) < 4) begin
            pulse_redirect($urandom() & 32'h000f_fffc);
         end else begin
            tick();
         end
      end
      check1("random_progress", (deliv_cnt - d0) >= 50, 1'b1);
      mem_lat   = 1;
      ready_pct = 100;
      out_pct   = 100;
      wait_deliv("final_live", 4, 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
